wb_uart: RTL and testbench
==========================

Name: wb_uart

Overview:
- Wishbone slave UART peripheral, the next slave hung off the main NIC behind rv_core, alongside the TCM. Selected by the NIC slot for address region 0x1xxx_xxxx.
- Provides a buffered TX path, a single-byte RX holding register, a programmable baud divisor and an interrupt line.
- Bus-side handshake matches the TCM slave: i_sel qualifies the cycle, and ack is registered.

Parameters:
- TX_DEPTH_LOG2, 3: TX FIFO depth is 2**TX_DEPTH_LOG2 bytes.
- DEFAULT_DIV, 16'd867: reset value of the DIV register. Bit period = DIV+1 clocks.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_sel  in  1  slave select from NIC
- i_wb_addr  in  32  byte address; only [3:2] decoded
- i_wb_stb  in  1  strobe
- i_wb_cyc  in  1  cycle
- i_wb_we  in  1  write enable
- i_wb_sel  in  4  byte lanes; lane 0 required for DATA writes
- i_wb_wdata  in  32  write data
- o_wb_ack  out  1  single-cycle acknowledge
- o_wb_rdata  out  32  read data, valid while o_wb_ack=1
- i_rx  in  1  serial input, asynchronous
- o_tx  out  1  serial output, idle high
- o_irq  out  1  level interrupt

Behaviour:
- Reset values: o_tx=1, o_wb_ack=0, o_wb_rdata=0, o_irq=0; FIFO empty; DIV=DEFAULT_DIV; CTRL=0; all flags 0.
- Access condition: access = i_sel & i_wb_cyc & i_wb_stb & ~o_wb_ack.
- Ack timing: o_wb_ack=1 exactly one cycle after access, for one cycle only. Register side effects take place in the access cycle. A held strobe therefore produces ack on every other cycle.
- Register map, addr[3:2]:
  - 0 DATA
    - Write (sel[0]): push wdata[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped and STATUS.tx_ovf is set.
    - Read: returns {24'b0, rx_byte} and clears rx_valid.
  - 1 STATUS (read-only)
    - Bits: [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_busy, [5] frame_err, [6] tx_ovf, [7] parity_err.
    - Bits 3, 5, 6 and 7 clear when STATUS is read.
  - 2 DIV
    - Read/write [15:0]; upper bits read as 0.
    - A write takes effect at the next bit boundary. A value of 0 is treated as 1.
  - 3 CTRL
    - [0] irq_rx_en, [1] irq_tx_empty_en.
- Interrupt: o_irq registered = (irq_rx_en & rx_valid) | (irq_tx_empty_en & tx_empty & ~tx_busy).
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each state lasts DIV+1 clocks; DATA shifts 8 bits LSB first.
  - The FIFO pops on the IDLE->START transition.
  - At the end of STOP, if the FIFO is not empty, the FSM goes directly to START (back-to-back frames, no idle gap).
  - tx_busy = state != IDLE.
- RX path: i_rx goes through a 2-FF synchroniser.
  - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - A falling edge in IDLE enters START. At (DIV+1)/2 clocks, if the line is high the FSM aborts to IDLE (glitch); otherwise it samples at full bit periods from that point.
  - A low stop bit sets frame_err; the byte is still stored.
  - On storing a byte: rx_byte <= data and rx_valid <= 1. If rx_valid was already 1, rx_overrun is set and the new byte overwrites the old one.
- Simultaneous events:
  - A CPU DATA read in the same cycle as an RX store: the store wins and rx_valid stays 1; the read returns the old byte.
  - A push and a pop in the same cycle on a full FIFO: the push is accepted.
- Reset mid-frame: FSMs return to IDLE immediately and o_tx goes high in the next cycle. A partial RX byte is discarded.

Optional Feature:
- WB_UART_PARITY_EN
  - Defined: TX inserts an even parity bit after the data bits. RX checks it and sets STATUS[7] parity_err on mismatch.
  - Undefined: no PARITY states (8N1 framing) and STATUS[7] reads 0.

Decomposition:
- Package uart_pkg:
  - Register offset constants for DATA, STATUS, DIV, CTRL.
  - STATUS bit index constants.
  - Enum typedef uart_state_t {IDLE, START, DATA, PARITY, STOP}, shared by the TX and RX FSMs.
- Sub-module uart_fifo: synchronous FIFO parameterised by width and depth-log2, with full/empty flags and first-word-fall-through output. Instantiated for TX.

Test Plan:
- Reset, then read STATUS: rdata=0x02 (tx_empty), DIV reads 867, o_tx=1, ack arrives exactly 1 cycle after stb.
- DIV=3, write DATA 0xA5: o_tx is low for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high; tx_busy=0 after 40 clks.
- DIV=3, write 9 bytes back-to-back with TX_DEPTH_LOG2=3 while the first byte is still in progress: no bytes lost, frames contiguous with no gap. A 10th write with the FIFO full sets tx_ovf=1, and reading STATUS clears it.
- DIV=3, drive 0x3C 8N1 on i_rx, with CTRL=1: rx_valid=1 and o_irq=1. DATA read returns 0x3C and o_irq drops.
- Send two bytes without reading: rx_overrun=1 and DATA returns the second byte. A 1-clock low glitch on i_rx produces no rx_valid. A low stop bit gives frame_err=1.
- Assert i_reset mid-TX frame: o_tx=1 in the next cycle, FIFO empty, STATUS=0x02.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and serial FSM state type for wb_uart.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_RX_VALID   = 2;
   localparam int unsigned ST_RX_OVERRUN = 3;
   localparam int unsigned ST_TX_BUSY    = 4;
   localparam int unsigned ST_FRAME_ERR  = 5;
   localparam int unsigned ST_TX_OVF     = 6;
   localparam int unsigned ST_PARITY_ERR = 7;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through output; a push on a full FIFO
// is accepted when a pop happens in the same cycle.
module uart_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0]      mem_q [1 << DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  push_ok, pop_ok;

   // count never exceeds the depth, so its MSB alone flags full
   assign o_full  = count_q[DEPTH_LOG2];
   assign o_empty = (count_q == '0);
   assign o_rdata = mem_q[rd_ptr_q];

   assign push_ok = i_push & (~o_full | i_pop);
   assign pop_ok  = i_pop & ~o_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok & ~pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok & ~push_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
   end

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART slave: buffered TX, single-byte RX holding register, baud divisor, irq.
// Define WB_UART_PARITY_EN for 8E1 framing with RX parity checking (default 8N1).
module wb_uart
   import uart_pkg::*;
#(
   parameter int unsigned TX_DEPTH_LOG2 = 3,
   parameter logic [15:0] DEFAULT_DIV   = 16'd867
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_sel,
   input  logic [31:0] i_wb_addr,
   input  logic        i_wb_stb,
   input  logic        i_wb_cyc,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_wdata,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_rdata,
   input  logic        i_rx,
   output logic        o_tx,
   output logic        o_irq
);

   logic        ack_q, ack_d, irq_q, irq_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] div_q, div_d, div_eff, rx_half_m1;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [7:0]  rx_byte_q, rx_byte_d, status;
   logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
   logic        frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d, parity_err_q, parity_err_d;
   logic        access, bus_wr, bus_rd;
   logic [1:0]  reg_addr;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;

   uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic        tx_q, tx_d, tx_load, tx_busy;
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic        rx_store, rx_frame_bad, rx_par_bad;
`ifdef WB_UART_PARITY_EN
   logic        tx_par_q, tx_par_d;
`endif

   logic unused_bits;
   assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_sel[3:1], i_wb_wdata[31:16]};

   assign access   = i_sel & i_wb_cyc & i_wb_stb & ~ack_q;
   assign bus_wr   = access & i_wb_we;
   assign bus_rd   = access & ~i_wb_we;
   assign reg_addr = i_wb_addr[3:2];

   assign fifo_push  = bus_wr & (reg_addr == REG_DATA) & i_wb_sel[0];
   assign div_eff    = eff_div(div_q);
   assign rx_half_m1 = (div_eff >> 1) + {15'd0, div_eff[0]} - 16'd1;
   assign tx_busy    = (tx_state_q != IDLE);

   uart_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (TX_DEPTH_LOG2)
   ) u_tx_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (fifo_push),
      .i_wdata (i_wb_wdata[7:0]),
      .i_pop   (fifo_pop),
      .o_rdata (fifo_dout),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // TX: every bit boundary reloads the counter, so DIV writes apply there
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      tx_load    = 1'b0;
      fifo_pop   = 1'b0;
`ifdef WB_UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      if (tx_state_q == IDLE) begin
         tx_d    = 1'b1;
         tx_load = ~fifo_empty;
      end else if (tx_cnt_q != 16'd0) begin
         tx_cnt_d = tx_cnt_q - 16'd1;
      end else begin
         tx_cnt_d = div_eff;
         case (tx_state_q)
            START: begin
               tx_state_d = DATA;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
            end
            DATA: begin
               if (tx_bit_q == 3'd7) begin
`ifdef WB_UART_PARITY_EN
                  tx_state_d = PARITY;
                  tx_d       = tx_par_q;
`else
                  tx_state_d = STOP;
                  tx_d       = 1'b1;
`endif
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end
            PARITY: begin
               tx_state_d = STOP;
               tx_d       = 1'b1;
            end
            default: begin
               tx_d = 1'b1;
               if (fifo_empty) tx_state_d = IDLE;
               else            tx_load    = 1'b1;
            end
         endcase
      end
      if (tx_load) begin
         fifo_pop   = 1'b1;
         tx_state_d = START;
         tx_cnt_d   = div_eff;
         tx_shift_d = fifo_dout;
         tx_d       = 1'b0;
`ifdef WB_UART_PARITY_EN
         tx_par_d   = ^fifo_dout;
`endif
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_store     = 1'b0;
      rx_frame_bad = 1'b0;
      rx_par_bad   = 1'b0;
      if (rx_state_q == IDLE) begin
         if (rx_prev_q & ~rx_sync_q) begin
            rx_state_d = START;
            rx_cnt_d   = rx_half_m1;
         end
      end else if (rx_cnt_q != 16'd0) begin
         rx_cnt_d = rx_cnt_q - 16'd1;
      end else begin
         rx_cnt_d = div_eff;
         case (rx_state_q)
            START: begin
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? IDLE : DATA;
            end
            DATA: begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
`ifdef WB_UART_PARITY_EN
                  rx_state_d = PARITY;
`else
                  rx_state_d = STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
            PARITY: begin
               rx_par_bad = rx_sync_q ^ (^rx_shift_q);
               rx_state_d = STOP;
            end
            default: begin
               rx_store     = 1'b1;
               rx_frame_bad = ~rx_sync_q;
               rx_state_d   = IDLE;
            end
         endcase
      end
   end

   // Bus side: register writes, read-to-clear side effects, then hardware sets take priority
   always_comb begin
      div_d        = div_q;
      ctrl_d       = ctrl_q;
      rx_byte_d    = rx_byte_q;
      rx_valid_d   = rx_valid_q;
      rx_overrun_d = rx_overrun_q;
      frame_err_d  = frame_err_q;
      tx_ovf_d     = tx_ovf_q;
      parity_err_d = parity_err_q;

      status                = '0;
      status[ST_TX_FULL]    = fifo_full;
      status[ST_TX_EMPTY]   = fifo_empty;
      status[ST_RX_VALID]   = rx_valid_q;
      status[ST_RX_OVERRUN] = rx_overrun_q;
      status[ST_TX_BUSY]    = tx_busy;
      status[ST_FRAME_ERR]  = frame_err_q;
      status[ST_TX_OVF]     = tx_ovf_q;
      status[ST_PARITY_ERR] = parity_err_q;

      rdata_d = '0;
      if (bus_rd) begin
         case (reg_addr)
            REG_DATA:   rdata_d = {24'd0, rx_byte_q};
            REG_STATUS: rdata_d = {24'd0, status};
            REG_DIV:    rdata_d = {16'd0, div_q};
            default:    rdata_d = {30'd0, ctrl_q};
         endcase
         if (reg_addr == REG_DATA) rx_valid_d = 1'b0;
         if (reg_addr == REG_STATUS) begin
            rx_overrun_d = 1'b0;
            frame_err_d  = 1'b0;
            tx_ovf_d     = 1'b0;
            parity_err_d = 1'b0;
         end
      end
      if (bus_wr & (reg_addr == REG_DIV))  div_d  = i_wb_wdata[15:0];
      if (bus_wr & (reg_addr == REG_CTRL)) ctrl_d = i_wb_wdata[1:0];

      if (fifo_push & fifo_full & ~fifo_pop) tx_ovf_d = 1'b1;
      if (rx_store) begin
         rx_byte_d  = rx_shift_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q)   rx_overrun_d = 1'b1;
         if (rx_frame_bad) frame_err_d  = 1'b1;
      end
      if (rx_par_bad) parity_err_d = 1'b1;

      ack_d = access;
      irq_d = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & fifo_empty & ~tx_busy);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ack_q        <= 1'b0;
         rdata_q      <= '0;
         irq_q        <= 1'b0;
         div_q        <= DEFAULT_DIV;
         ctrl_q       <= '0;
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         frame_err_q  <= 1'b0;
         tx_ovf_q     <= 1'b0;
         parity_err_q <= 1'b0;
         tx_state_q   <= IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_q         <= 1'b1;
         rx_state_q   <= IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
`ifdef WB_UART_PARITY_EN
         tx_par_q     <= 1'b0;
`endif
      end else begin
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         irq_q        <= irq_d;
         div_q        <= div_d;
         ctrl_q       <= ctrl_d;
         rx_byte_q    <= rx_byte_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
         frame_err_q  <= frame_err_d;
         tx_ovf_q     <= tx_ovf_d;
         parity_err_q <= parity_err_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_q         <= tx_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_meta_q    <= i_rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
`ifdef WB_UART_PARITY_EN
         tx_par_q     <= tx_par_d;
`endif
      end
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_rdata = rdata_q;
   assign o_tx       = tx_q;
   assign o_irq      = irq_q;

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart in its default 8N1 build.
module tb_wb_uart;

   localparam logic [31:0] A_DATA   = 32'h1000_0000;
   localparam logic [31:0] A_STATUS = 32'h1000_0004;
   localparam logic [31:0] A_DIV    = 32'h1000_0008;
   localparam logic [31:0] A_CTRL   = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  bsel = '0;
   logic        rx = 1'b1;
   logic        ack, tx, irq;
   logic [31:0] rdata;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [399:0] cap;

   always #5 clk = ~clk;

   wb_uart #(
      .TX_DEPTH_LOG2 (3),
      .DEFAULT_DIV   (16'd867)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_sel      (sel),
      .i_wb_addr  (addr),
      .i_wb_stb   (stb),
      .i_wb_cyc   (cyc),
      .i_wb_we    (we),
      .i_wb_sel   (bsel),
      .i_wb_wdata (wdata),
      .o_wb_ack   (ack),
      .o_wb_rdata (rdata),
      .i_rx       (rx),
      .o_tx       (tx),
      .o_irq      (irq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q, output int lat);
      @(posedge clk); #1;
      sel = 1'b1; cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; bsel = 4'hF;
      lat = 0;
      q   = '0;
      while (lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (ack === 1'b1) break;
      end
      if (ack !== 1'b1) check("ack_timeout", 64'(lat), 64'd1);
      q = rdata;
      sel = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] q;
      int lat;
      wb_xfer(1'b1, a, d, q, lat);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
      int lat;
      wb_xfer(1'b0, a, '0, q, lat);
   endtask

   task automatic capture(input int n);
      int t = 0;
      @(negedge clk);
      while (tx !== 1'b0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("tx_start_seen", 64'(t < 300), 64'd1);
      for (int i = 0; i < n; i++) begin
         cap[i] = tx;
         @(negedge clk);
      end
   endtask

   function automatic logic [39:0] frame40(input logic [7:0] b);
      logic [9:0]  fb;
      logic [39:0] f;
      fb = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < 4; j++) f[k*4+j] = fb[k];
      return f;
   endfunction

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fb;
      fb = {stop, b, 1'b0};
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         rx = fb[k];
         repeat (4) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   logic [7:0]  bytes9 [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h96, 8'h3C};
   logic [31:0] q;
   logic [3:0]  ack_pat;
   int          lat;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_tx", 64'(tx), 64'd1);
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_irq", 64'(irq), 64'd0);
      check("reset_rdata", 64'(rdata), 64'd0);
      wb_xfer(1'b0, A_STATUS, '0, q, lat);
      check("reset_status", 64'(q), 64'h02);
      check("ack_latency", 64'(lat), 64'd1);
      wb_read(A_DIV, q);
      check("reset_div", 64'(q), 64'd867);

      // held strobe: ack on alternate cycles
      @(posedge clk); #1;
      sel = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_STATUS;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         ack_pat[i] = ack;
      end
      sel = 1'b0; cyc = 1'b0; stb = 1'b0;
      check("held_stb_ack", 64'(ack_pat), 64'b0101);

      // single byte frame
      wb_write(A_DIV, 32'd3);
      fork
         capture(44);
         wb_write(A_DATA, 32'hA5);
      join
      check("frame_a5", 64'(cap[39:0]), 64'(frame40(8'hA5)));
      check("idle_after_a5", 64'(cap[43:40]), 64'hF);
      wb_read(A_STATUS, q);
      check("status_after_a5", 64'(q), 64'h02);

      // nine back-to-back bytes fill the FIFO behind the active frame, tenth overflows
      fork
         capture(360);
         begin
            for (int i = 0; i < 9; i++) wb_write(A_DATA, {24'd0, bytes9[i]});
            wb_write(A_DATA, 32'hEE);
            wb_read(A_STATUS, q);
            check("status_ovf", 64'(q), 64'h51);
            wb_read(A_STATUS, q);
            check("status_ovf_cleared", 64'(q), 64'h11);
         end
      join
      for (int f = 0; f < 9; f++)
         check($sformatf("frame_b2b_%0d", f), 64'(cap[f*40 +: 40]), 64'(frame40(bytes9[f])));
      repeat (4) @(posedge clk);
      wb_read(A_STATUS, q);
      check("status_after_b2b", 64'(q), 64'h02);

      // receive with rx interrupt enabled
      wb_write(A_CTRL, 32'd1);
      send_rx(8'h3C, 1'b1);
      check("irq_rx", 64'(irq), 64'd1);
      wb_read(A_STATUS, q);
      check("status_rx_valid", 64'(q), 64'h06);
      wb_read(A_DATA, q);
      check("rx_data_3c", 64'(q), 64'h3C);
      repeat (2) @(posedge clk);
      #1 check("irq_cleared", 64'(irq), 64'd0);

      send_rx(8'h81, 1'b1);
      send_rx(8'h42, 1'b1);
      wb_read(A_STATUS, q);
      check("status_overrun", 64'(q), 64'h0E);
      wb_read(A_DATA, q);
      check("rx_data_overwritten", 64'(q), 64'h42);
      wb_read(A_STATUS, q);
      check("status_overrun_cleared", 64'(q), 64'h02);

      @(posedge clk); #1 rx = 1'b0;
      @(posedge clk); #1 rx = 1'b1;
      repeat (20) @(posedge clk);
      wb_read(A_STATUS, q);
      check("glitch_ignored", 64'(q), 64'h02);

      send_rx(8'h55, 1'b0);
      wb_read(A_STATUS, q);
      check("status_frame_err", 64'(q), 64'h26);
      wb_read(A_DATA, q);
      check("rx_data_bad_stop", 64'(q), 64'h55);
      wb_read(A_STATUS, q);
      check("status_frame_err_cleared", 64'(q), 64'h02);

      // reset in the middle of a frame with bytes still queued
      wb_write(A_DATA, 32'hF0);
      wb_write(A_DATA, 32'h12);
      wb_write(A_DATA, 32'h34);
      repeat (4) @(posedge clk);
      #1 check("tx_low_mid_frame", 64'(tx), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("tx_high_after_reset", 64'(tx), 64'd1);
      rst = 1'b0;
      wb_read(A_STATUS, q);
      check("status_after_reset", 64'(q), 64'h02);
      wb_read(A_DIV, q);
      check("div_after_reset", 64'(q), 64'd867);
      repeat (50) @(posedge clk);
      #1 check("tx_stays_idle", 64'(tx), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
